// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache: one whole-line
// transaction at a time, round-robin when both ask, saturating grant counters.
module l2_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;
  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       done;

  // Arbitration and transaction sequencing; only IDLE samples new requests.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    i_req      = i_read;
    d_req      = d_read | d_write;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last_grant == GRANT_D))) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // L2 request registers, round-robin pointer and grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l2_address  <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      l2_wdata    <= '0;
      last_grant  <= GRANT_I;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else if (grant_i) begin
      l2_address <= i_address;
      l2_read    <= 1'b1;
      l2_write   <= 1'b0;
      last_grant <= GRANT_I;
      if (i_grant_cnt != CNT_MAX) i_grant_cnt <= i_grant_cnt + CNT_WIDTH'(1);
    end else if (grant_d) begin
      l2_address <= d_address;
      l2_wdata   <= d_wdata;
      l2_read    <= ~d_write;
      l2_write   <= d_write;
      last_grant <= GRANT_D;
      if (d_grant_cnt != CNT_MAX) d_grant_cnt <= d_grant_cnt + CNT_WIDTH'(1);
    end else if (done) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
    end
  end

  // Completion is routed only to the side being served.
  assign i_resp  = (state == SERVE_I) && l2_resp;
  assign d_resp  = (state == SERVE_D) && l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomised scoreboard bench for l2_arbiter: requester drivers push expected
// transactions, a negedge monitor checks grants and completions against them.
module tb_l2_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;
  localparam int unsigned CW = 4;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_address;
  logic          i_read;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic [AW-1:0] d_address;
  logic          d_read;
  logic          d_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] l2_address;
  logic          l2_read;
  logic          l2_write;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic [CW-1:0] i_grant_cnt;
  logic [CW-1:0] d_grant_cnt;

  int total = 0;
  int bad   = 0;
  int n_i   = 0;
  int n_d   = 0;
  int lat_mode = -1;

  txn_t          exp_i[$];
  txn_t          exp_d[$];
  bit            grant_log[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] l2_mem  [logic [AW-1:0]];

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [LW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic bit side_of(input logic [AW-1:0] a);
    return a >= AW'(16'h1000);
  endfunction

  function automatic logic [CW-1:0] sat(input int n);
    return (n >= (1 << CW) - 1) ? '1 : CW'(n);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // L2 model: fixed or random latency, backing store for read-after-write.
  int wait_n;
  bit busy;
  initial begin
    l2_resp  = 1'b0;
    l2_rdata = '0;
    busy     = 1'b0;
    wait_n   = 0;
    forever begin
      @(posedge clk); #1;
      l2_resp = 1'b0;
      if (!(l2_read || l2_write)) busy = 1'b0;
      else begin
        if (!busy) begin
          busy   = 1'b1;
          wait_n = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (wait_n == 0) begin
          l2_resp = 1'b1;
          busy    = 1'b0;
          if (l2_write) begin
            l2_mem[l2_address] = l2_wdata;
            l2_rdata = rnd_line();
          end else begin
            l2_rdata = l2_mem.exists(l2_address) ? l2_mem[l2_address] : init_line(l2_address);
          end
        end else wait_n--;
      end
    end
  end

  // Monitor: grant latency/fairness from sampled requests, completion scoreboard.
  bit   strobe, prev_strobe, prev_ireq, prev_dreq, mon_last, exp_side;
  txn_t me;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mon_last    = 1'b0;
      prev_strobe = 1'b0;
      prev_ireq   = 1'b0;
      prev_dreq   = 1'b0;
    end else begin
      strobe = l2_read || l2_write;
      if (!prev_strobe) begin
        if (prev_ireq || prev_dreq) begin
          exp_side = (prev_ireq && prev_dreq) ? !mon_last : prev_dreq;
          chk("grant_latency", LW'(strobe), LW'(1));
          chk("grant_side", LW'(side_of(l2_address)), LW'(exp_side));
          if (strobe) grant_log.push_back(side_of(l2_address));
          mon_last = exp_side;
        end else begin
          chk("no_grant_without_req", LW'(strobe), LW'(0));
        end
      end
      if (l2_resp && strobe)
        chk("resp_side", LW'({i_resp, d_resp}), side_of(l2_address) ? LW'(1) : LW'(2));
      else
        chk("resp_idle", LW'({i_resp, d_resp}), LW'(0));
      if (i_resp) begin
        if (exp_i.size() == 0) chk("i_resp_unexpected", LW'(1), LW'(0));
        else begin
          me = exp_i.pop_front();
          chk("i_addr", LW'(l2_address), LW'(me.addr));
          chk("i_op", LW'({l2_read, l2_write}), LW'(2));
          chk("i_rdata", i_rdata, me.data);
        end
      end
      if (d_resp) begin
        if (exp_d.size() == 0) chk("d_resp_unexpected", LW'(1), LW'(0));
        else begin
          me = exp_d.pop_front();
          chk("d_addr", LW'(l2_address), LW'(me.addr));
          chk("d_op", LW'({l2_read, l2_write}), me.wr ? LW'(1) : LW'(2));
          if (me.wr) chk("d_wdata", l2_wdata, me.data);
          else       chk("d_rdata", d_rdata, me.data);
        end
      end
      prev_strobe = strobe;
      prev_ireq   = i_read;
      prev_dreq   = d_read || d_write;
    end
  end

  task automatic issue_i(input logic [AW-1:0] a);
    txn_t e;
    int   k;
    e.wr = 1'b0; e.addr = a; e.data = ref_get(a);
    exp_i.push_back(e);
    n_i++;
    i_address = a;
    i_read    = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_resp) break;
    end
    chk("i_done_in_time", LW'(k < 200), LW'(1));
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic issue_d(input logic [AW-1:0] a, input bit wr, input bit both, input logic [LW-1:0] wd);
    txn_t e;
    int   k;
    e.wr = wr; e.addr = a;
    if (wr) begin e.data = wd; ref_mem[a] = wd; end
    else e.data = ref_get(a);
    exp_d.push_back(e);
    n_d++;
    d_address = a;
    d_wdata   = wd;
    d_write   = wr;
    d_read    = !wr || both;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_resp) break;
      if ((l2_read || l2_write) && l2_address == a) begin
        chk("d_strobe_op", LW'({l2_read, l2_write}), wr ? LW'(1) : LW'(2));
        if (wr) chk("d_wdata_hold", l2_wdata, wd);
      end
    end
    chk("d_done_in_time", LW'(k < 200), LW'(1));
    @(posedge clk); #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_i = 0;
    n_d = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [3:0] ord;
  bit         found;
  initial begin
    rst = 1'b0; i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    ref_mem[16'h0040] = {16{8'hA5}};
    l2_mem[16'h0040]  = {16{8'hA5}};
    #1 rst = 1'b1;
    #1;
    chk("rst_l2_read", LW'(l2_read), LW'(0));
    chk("rst_l2_write", LW'(l2_write), LW'(0));
    chk("rst_l2_address", LW'(l2_address), LW'(0));
    chk("rst_l2_wdata", l2_wdata, LW'(0));
    chk("rst_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'(0));
    chk("rst_resps", LW'({i_resp, d_resp}), LW'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // I-cache only, L2 answers three cycles after the strobe rises.
    lat_mode = 3;
    @(posedge clk); #1;
    exp_i.push_back('{1'b0, 16'h0040, {16{8'hA5}}});
    n_i++;
    i_address = 16'h0040;
    i_read    = 1'b1;
    @(negedge clk); chk("c0_l2_read", LW'(l2_read), LW'(0));
    @(negedge clk); chk("c1_l2_read", LW'(l2_read), LW'(1));
    chk("c1_l2_address", LW'(l2_address), LW'(16'h0040));
    @(negedge clk); chk("c2_i_resp", LW'(i_resp), LW'(0));
    @(negedge clk); chk("c3_i_resp", LW'(i_resp), LW'(0));
    @(negedge clk); chk("c4_i_resp", LW'(i_resp), LW'(1));
    chk("c4_i_rdata", i_rdata, {16{8'hA5}});
    @(posedge clk); #1; i_read = 1'b0;
    @(negedge clk); chk("c5_l2_read", LW'(l2_read), LW'(0));
    chk("c5_i_cnt", LW'(i_grant_cnt), LW'(1));

    // D-cache writeback with both d_read and d_write high: write wins.
    lat_mode = 2;
    issue_d(16'h1230, 1'b1, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("wb_d_cnt", LW'(d_grant_cnt), LW'(1));
    issue_d(16'h1230, 1'b0, 1'b0, rnd_line());

    // Simultaneous held requests right after reset: D, I, D, I.
    reset_dut();
    lat_mode = 1;
    grant_log.delete();
    fork
      begin repeat (2) issue_i({4'h0, 8'($urandom_range(0, 255)), 4'h0}); end
      begin repeat (2) issue_d({8'h11, 4'($urandom_range(0, 15)), 4'h0}, 1'b0, 1'b0, rnd_line()); end
    join
    chk("rr_grant_count", LW'(grant_log.size()), LW'(4));
    ord = 4'b0000;
    if (grant_log.size() >= 4) ord = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
    chk("rr_grant_order", LW'(ord), LW'(4'b1010));
    chk("rr_i_cnt", LW'(i_grant_cnt), LW'(2));
    chk("rr_d_cnt", LW'(d_grant_cnt), LW'(2));

    // Spurious L2 completion while idle.
    repeat (2) @(posedge clk);
    #2 l2_resp = 1'b1;
    @(negedge clk);
    chk("spurious_resps", LW'({i_resp, d_resp}), LW'(0));
    @(posedge clk); #2 l2_resp = 1'b0;
    @(negedge clk);
    chk("spurious_strobes", LW'({l2_read, l2_write}), LW'(0));
    chk("spurious_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'({4'd2, 4'd2}));

    // Random traffic from both sides with random gaps and L2 latencies.
    lat_mode = -1;
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_i({4'h0, 8'($urandom_range(0, 255)), 4'h0});
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_d({8'h10, 4'($urandom_range(0, 15)), 4'h0}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rnd_line());
        end
      end
    join
    chk("rand_i_cnt", LW'(i_grant_cnt), LW'(sat(n_i)));
    chk("rand_d_cnt", LW'(d_grant_cnt), LW'(sat(n_d)));
    chk("rand_queues_drained", LW'(exp_i.size() + exp_d.size()), LW'(0));

    // Reset in the middle of a D writeback, checked before any clock edge.
    lat_mode = 20;
    @(posedge clk); #1;
    d_address = 16'h1500; d_wdata = rnd_line(); d_write = 1'b1; d_read = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (l2_write) begin found = 1'b1; break; end
    end
    chk("mid_rst_serving", LW'(found), LW'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_l2_write", LW'({l2_read, l2_write}), LW'(0));
    chk("mid_rst_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'(0));
    chk("mid_rst_resps", LW'({i_resp, d_resp}), LW'(0));
    d_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_i = 0;
    n_d = 0;

    // Counter saturation: sixteen I grants, count must hold at all-ones.
    lat_mode = 0;
    for (int k = 1; k <= 16; k++) begin
      issue_i({4'h0, 8'(k), 4'h0});
      chk("sat_i_cnt", LW'(i_grant_cnt), LW'(sat(k)));
    end
    chk("sat_d_cnt", LW'(d_grant_cnt), LW'(0));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
